// File: rtl/md_ctrl.sv
// HI/LO multiply/divide controller for the E stage: decodes MD instructions,
// sequences multi-cycle MULT/DIV with a countdown and owns HI/LO.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_d_instr,
  output logic        out_start,
  output logic        out_busy,
  output logic        out_stall,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  // MD-class functs are 0x10..0x13 and 0x18..0x1B under the Special opcode.
  function automatic logic is_md(input logic [31:0] instr);
    return (instr[31:26] == 6'd0) &&
           ((instr[5:2] == 4'b0100) || (instr[5:2] == 4'b0110));
  endfunction

  logic        special;
  logic [5:0]  funct;
  logic        is_mult;
  logic        is_div;
  logic        is_signed;
  logic        is_mthi;
  logic        is_mtlo;

  logic [3:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;

  logic [63:0] product;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_by;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  logic unused_bits;
  assign unused_bits = ^{in_instr[25:6], in_d_instr[25:6]};

  assign special   = (in_instr[31:26] == 6'd0);
  assign funct     = in_instr[5:0];
  assign is_mult   = special && (funct == F_MULT || funct == F_MULTU);
  assign is_div    = special && (funct == F_DIV  || funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign is_mthi   = special && (funct == F_MTHI);
  assign is_mtlo   = special && (funct == F_MTLO);

  assign out_start = (is_mult || is_div) && !out_busy;
  assign out_stall = is_md(in_d_instr) && (out_start || out_busy);

  // Low 64 bits of the extended product are correct for both signednesses.
  assign product = {{32{is_signed & in_a[31]}}, in_a} *
                   {{32{is_signed & in_b[31]}}, in_b};

  // Sign-magnitude divide: avoids the undefined 0x80000000 / -1 corner of a
  // native signed divide and gives remainder the sign of the dividend.
  assign neg_a    = is_signed & in_a[31];
  assign neg_b    = is_signed & in_b[31];
  assign mag_a    = neg_a ? (~in_a + 32'd1) : in_a;
  assign mag_b    = neg_b ? (~in_b + 32'd1) : in_b;
  assign div_by   = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quot_mag = mag_a / div_by;
  assign rem_mag  = mag_a % div_by;
  assign quot     = (neg_a ^ neg_b) ? (~quot_mag + 32'd1) : quot_mag;
  assign rem      = neg_a ? (~rem_mag + 32'd1) : rem_mag;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_busy <= 1'b0;
      count    <= 4'd0;
      out_hi   <= 32'd0;
      out_lo   <= 32'd0;
      pend_hi  <= 32'd0;
      pend_lo  <= 32'd0;
      pend_dz  <= 1'b0;
    end else if (out_busy) begin
      // Anything arriving in E while busy is ignored.
      if (count == 4'd1) begin
        out_busy <= 1'b0;
        if (!pend_dz) begin
          out_hi <= pend_hi;
          out_lo <= pend_lo;
        end
      end
      if (count != 4'd0) count <= count - 4'd1;
    end else if (out_start) begin
      out_busy <= 1'b1;
      if (is_mult) begin
        pend_hi <= product[63:32];
        pend_lo <= product[31:0];
        pend_dz <= 1'b0;
        count   <= 4'(MULT_CYCLES);
      end else begin
        pend_hi <= rem;
        pend_lo <= quot;
        pend_dz <= (in_b == 32'd0);
        count   <= 4'(DIV_CYCLES);
      end
    end else begin
      if (is_mthi) out_hi <= in_a;
      if (is_mtlo) out_lo <= in_a;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: table of per-cycle vectors plus a
// hand-written reset-abort sequence.
module tb_md_ctrl;

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_MULT  = 32'h0085_0018;
  localparam logic [31:0] I_MULTU = 32'h0085_0019;
  localparam logic [31:0] I_DIV   = 32'h0085_001A;
  localparam logic [31:0] I_DIVU  = 32'h0085_001B;
  localparam logic [31:0] I_MTHI  = 32'h0080_0011;
  localparam logic [31:0] I_MTLO  = 32'h0080_0013;
  localparam logic [31:0] I_MFLO  = 32'h0000_1012;
  localparam logic [31:0] I_ADDU  = 32'h0022_1821;
  localparam logic [31:0] I_LW18  = 32'h8C85_0018;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_instr, in_a, in_b, in_d_instr;
  logic        out_start, out_busy, out_stall;
  logic [31:0] out_hi, out_lo;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_instr   (in_instr),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_d_instr (in_d_instr),
    .out_start  (out_start),
    .out_busy   (out_busy),
    .out_stall  (out_stall),
    .out_hi     (out_hi),
    .out_lo     (out_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [31:0] i, a, b, d,
                              input logic s, bz, st, input logic [31:0] h, l);
    vecs.push_back('{i, a, b, d, s, bz, st, h, l});
  endfunction

  // Busy cycles with a bubble in E.
  function automatic void add_busy(input int n, input logic [31:0] d, input logic st,
                                   input logic [31:0] h, l);
    for (int k = 0; k < n; k++) add(I_NOP, 0, 0, d, 1'b0, 1'b1, st, h, l);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_instr = 0; in_a = 0; in_b = 0; in_d_instr = 0;

    // Reset state, then MULT -3*5
    add(I_NOP,  0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    add(I_LW18, 32'h3, 32'h3, 0, 0, 0, 0, 32'h0, 32'h0);
    add(I_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1, 0, 0, 32'h0, 32'h0);
    add_busy(5, 0, 0, 32'h0, 32'h0);
    // Back-to-back MULTU in the cycle busy falls
    add(I_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    add_busy(5, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    // DIV -7/2 with MFLO in D; MTHI and another DIV arrive while busy
    add(I_DIV, 32'hFFFF_FFF9, 32'd2, I_MFLO, 1, 0, 1, 32'h1, 32'hFFFF_FFFE);
    add_busy(2, I_MFLO, 1, 32'h1, 32'hFFFF_FFFE);
    add(I_MTHI, 32'hAAAA_0000, 0, I_MFLO, 0, 1, 1, 32'h1, 32'hFFFF_FFFE);
    add_busy(2, I_MFLO, 1, 32'h1, 32'hFFFF_FFFE);
    add(I_DIV, 32'd1, 32'd1, I_MFLO, 0, 1, 1, 32'h1, 32'hFFFF_FFFE);
    add_busy(4, I_MFLO, 1, 32'h1, 32'hFFFF_FFFE);
    // Busy fell: stall drops; MTHI now takes effect next cycle
    add(I_MTHI, 32'hAAAA_0000, 0, I_MFLO, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // DIV overflow corner with non-MD instruction in D
    add(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, I_ADDU, 1, 0, 0, 32'hAAAA_0000, 32'hFFFF_FFFD);
    add_busy(10, I_ADDU, 0, 32'hAAAA_0000, 32'hFFFF_FFFD);
    add(I_MTHI, 32'h0000_1234, 0, 0, 0, 0, 0, 32'h0, 32'h8000_0000);
    add(I_MTLO, 32'h0000_5678, 0, 0, 0, 0, 0, 32'h1234, 32'h8000_0000);
    // DIVU by zero keeps prior HI/LO
    add(I_DIVU, 32'd9, 32'd0, 0, 1, 0, 0, 32'h1234, 32'h5678);
    add_busy(10, 0, 0, 32'h1234, 32'h5678);
    add(I_NOP, 0, 0, I_MFLO, 0, 0, 0, 32'h1234, 32'h5678);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      in_instr = vecs[i].instr; in_a = vecs[i].a; in_b = vecs[i].b; in_d_instr = vecs[i].d;
      #1;
      check($sformatf("v%0d start", i), {31'b0, out_start}, {31'b0, vecs[i].start});
      check($sformatf("v%0d busy",  i), {31'b0, out_busy},  {31'b0, vecs[i].busy});
      check($sformatf("v%0d stall", i), {31'b0, out_stall}, {31'b0, vecs[i].stall});
      check($sformatf("v%0d hi", i), out_hi, vecs[i].hi);
      check($sformatf("v%0d lo", i), out_lo, vecs[i].lo);
      next_cycle();
    end

    // Reset during the 3rd busy cycle of a DIV abandons it
    in_instr = I_DIV; in_a = 32'd100; in_b = 32'd7; in_d_instr = 0;
    #1 check("rst_seq start", {31'b0, out_start}, 32'd1);
    next_cycle();
    in_instr = I_NOP;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) reset = 1'b1;
      #1 check($sformatf("rst_seq busy%0d", k), {31'b0, out_busy}, 32'd1);
      next_cycle();
    end
    reset = 1'b0;
    check("rst_seq busy_after", {31'b0, out_busy}, 32'd0);
    check("rst_seq hi_after", out_hi, 32'd0);
    check("rst_seq lo_after", out_lo, 32'd0);
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      check($sformatf("rst_seq late_hi%0d", k), out_hi, 32'd0);
      check($sformatf("rst_seq late_lo%0d", k), out_lo, 32'd0);
      check($sformatf("rst_seq late_busy%0d", k), {31'b0, out_busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
